// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU followed by a 2-entry result FIFO.
// The ALU result and its flags are computed combinationally from a/b/opControl
// and written into the queue on acceptance. The head entry drives the outputs.
// The queue decouples operand fetch from writeback and branch resolution.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Operation codes produced by the ALU control decoder.
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110
  } op_e;

  // One queued result together with its flags.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sign_a;
  logic             sign_b;
  entry_t           alu_entry;

  assign sum    = a + b;
  assign diff   = a - b;
  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1];

  // Select the result for the presented opcode and derive its flags.
  always_comb begin
    // NOTE: every field gets a default before the case, so no path through
    // this block leaves a value unassigned (that would infer a latch).
    alu_entry          = '0;
    alu_entry.illegal  = 1'b0;
    alu_entry.overflow = 1'b0;
    unique case (opControl)
      OP_AND: alu_entry.result = a & b;
      OP_OR:  alu_entry.result = a | b;
      OP_ADD: begin
        alu_entry.result   = sum;
        // Same-sign operands whose sum flips sign.
        alu_entry.overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      OP_SUB: begin
        alu_entry.result   = diff;
        // Opposite-sign operands whose difference differs in sign from a.
        alu_entry.overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      default: begin
        // Unsupported codes, including the decoder's 4'b1111 "unknown".
        alu_entry.result  = '0;
        alu_entry.illegal = 1'b1;
      end
    endcase
    // NOTE: blocking assignments here because this is combinational logic;
    // the clocked blocks below use non-blocking assignments only.
    alu_entry.zero = (alu_entry.result == '0);
  end

  // ---------------------------------------------------------------------------
  // 2-entry result queue
  // ---------------------------------------------------------------------------
  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  entry_t     head;

  // Readiness depends only on registered occupancy and reset, never on
  // out_ready, so the upstream stage sees no combinational path from writeback.
  assign in_ready  = !reset && (count != 2'd2);
  // Entries about to be discarded by reset are not offered to the consumer.
  assign out_valid = !reset && (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Occupancy and pointer bookkeeping; pointers wrap modulo 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy gates every
    // read, so stale contents are never visible and no reset fan-out is needed.
    if (push) mem[wr_ptr] <= alu_entry;
  end

  // Saturating count of accepted illegal operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (push && alu_entry.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  // Head entry drives the outputs; an empty queue drives zeros.
  always_comb begin
    result   = '0;
    zero     = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    if (out_valid) begin
      result   = head.result;
      zero     = head.zero;
      overflow = head.overflow;
      illegal  = head.illegal;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed test-plan steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_exec_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       opControl = 4'b0000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  alu_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opControl  (opControl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
  } entry_t;

  // Reference model state: expected queue contents and illegal counter.
  entry_t exp_q[$];
  int     exp_cnt = 0;

  int errors = 0;
  int checks = 0;

  logic        d_push, d_pop;
  logic [31:0] d_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference ALU written from the arithmetic rules: overflow is detected by
  // doing the signed operation at 64 bits and checking it fits in 32.
  function automatic entry_t ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    entry_t e;
    longint sx, sy, full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e = '0;
    case (op)
      4'd0: e.result = x & y;
      4'd1: e.result = x | y;
      4'd2: begin
        full = sx + sy;
        e.result = x + y;
        e.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd6: begin
        full = sx - sy;
        e.result = x - y;
        e.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [31:0] x, input logic [31:0] y, input logic ordy,
                      output logic pushed, output logic popped, output logic [31:0] popped_res);
    entry_t h, e;
    logic   exp_ir, exp_ov;
    reset = rst; in_valid = v; opControl = op; a = x; b = y; out_ready = ordy;
    #1;
    exp_ir = !rst && (exp_q.size() < 2);
    exp_ov = !rst && (exp_q.size() != 0);
    h = '0;
    if (exp_ov) h = exp_q[0];
    check("in_ready",    in_ready,    exp_ir);
    check("out_valid",   out_valid,   exp_ov);
    check("result",      result,      h.result);
    check("zero",        zero,        h.zero);
    check("overflow",    overflow,    h.overflow);
    check("illegal",     illegal,     h.illegal);
    check("illegal_cnt", illegal_cnt, exp_cnt);
    pushed = v && exp_ir;
    popped = exp_ov && ordy;
    popped_res = result;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (pushed) begin
        e = ref_op(op, x, y);
        exp_q.push_back(e);
        if (e.illegal && exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic ordy);
    step(1'b0, 1'b1, op, x, y, ordy, d_push, d_pop, d_res);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, ordy, d_push, d_pop, d_res);
  endtask

  logic [31:0] got[$];
  logic [3:0]  op_tbl [4];

  initial begin
    op_tbl[0] = 4'd0; op_tbl[1] = 4'd1; op_tbl[2] = 4'd2; op_tbl[3] = 4'd6;

    // Bring the registers out of X before the model is trusted.
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset held: in_valid must be ignored and in_ready low.
    step(1'b1, 1'b1, 4'd2, 32'd1, 32'd1, 1'b1, d_push, d_pop, d_res);
    step(1'b1, 1'b1, 4'd2, 32'd1, 32'd1, 1'b1, d_push, d_pop, d_res);

    // Basic operations with the consumer always ready.
    do_op(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
    do_op(4'd1, 32'h0000000F, 32'h000000F0, 1'b1);
    do_op(4'd2, 32'd5, 32'd7, 1'b1);
    do_op(4'd6, 32'd5, 32'd5, 1'b1);
    idle(1'b1);

    // Overflow corners.
    do_op(4'd2, 32'h7FFFFFFF, 32'd1, 1'b1);
    do_op(4'd6, 32'h80000000, 32'd1, 1'b1);
    do_op(4'd2, 32'hFFFFFFFF, 32'd1, 1'b1);
    idle(1'b1);

    // Illegal codes.
    do_op(4'b1111, 32'h1234, 32'h5678, 1'b1);
    do_op(4'b0011, 32'h9ABC, 32'hDEF0, 1'b1);
    idle(1'b1);
    check("illegal_cnt_two", illegal_cnt, 2);

    // Saturation of the illegal counter.
    for (int i = 0; i < 300; i++) do_op(4'b1111, $urandom, $urandom, 1'b1);
    idle(1'b1);
    check("illegal_cnt_sat", illegal_cnt, CNT_MAX);

    // Backpressure: two accepts fill the queue, a third request is ignored.
    do_op(4'd2, 32'd1, 32'd1, 1'b0);
    do_op(4'd2, 32'd2, 32'd2, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    do_op(4'd2, 32'd3, 32'd3, 1'b0);
    check("bp_first", result, 32'd2);
    idle(1'b1);
    check("bp_ready_back", in_ready, 1'b1);
    check("bp_second", result, 32'd4);
    idle(1'b1);
    check("bp_empty", out_valid, 1'b0);

    // Back-to-back stream with out_ready toggling every cycle.
    begin
      int n = 0;
      for (int cyc = 0; cyc < 200 && (n < 20 || exp_q.size() != 0); cyc++) begin
        step(1'b0, n < 20, 4'd2, n, n, (cyc % 2) == 0, d_push, d_pop, d_res);
        if (d_push) n++;
        if (d_pop) got.push_back(d_res);
      end
      check("stream_len", got.size(), 20);
      for (int k = 0; k < 20; k++)
        if (k < got.size()) check("stream_val", got[k], 2 * k);
    end

    // Reset mid-stream with two queued entries; nothing stale may appear.
    do_op(4'd2, 32'd9, 32'd9, 1'b0);
    do_op(4'd2, 32'd10, 32'd10, 1'b0);
    step(1'b1, 1'b1, 4'd2, 32'd11, 32'd11, 1'b1, d_push, d_pop, d_res);
    check("post_rst_cnt", illegal_cnt, 0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic with occasional resets and boundary operands.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : op_tbl[$urandom_range(0, 3)];
      x  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, op, x, y,
           $urandom_range(0, 2) != 0, d_push, d_pop, d_res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
